// File: rtl/pixel_pair_rmw_pkg.sv
// Shared types and constants for the pixel-pair read-modify-write stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pixel_pair_rmw_pkg;

    localparam int NIB_W  = 4;
    localparam int PAIR_W = 8;

    // Slot index inside a pixel pair, in draw order along the line.
    localparam logic SLOT0 = 1'b0;
    localparam logic SLOT1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RD,
        ST_MRG,
        ST_WR,
        ST_SCAN
    } state_t;

    // The pair register keeps slot0 in the low nibble and slot1 in the high nibble.
    function automatic logic [NIB_W-1:0] slot_nib(input logic [PAIR_W-1:0] pair,
                                                  input logic              slot);
        return (slot == SLOT1) ? pair[PAIR_W-1:NIB_W] : pair[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_pair_rmw_if.sv
// Bundle of pixel-stream, DRAM and scan-out signals of the pixel-pair stage.
// Latency: n/a (wiring only).
// Backpressure: PIX_READY qualifies PIX_VALID; DRAM_DIN follows DRAM_RD by one cycle.
interface pixel_pair_rmw_if;
    import pixel_pair_rmw_pkg::*;

    logic                BLK;
    logic                PLUSONE;
    logic                S;
    logic [NIB_W-1:0]    PIX;
    logic                PIX_VALID;
    logic                PIX_LAST;
    logic                PIX_READY;
    logic [PAIR_W-1:0]   DRAM_DIN;
    logic [PAIR_W-1:0]   DRAM_DOUT;
    logic                DRAM_RD;
    logic                DRAM_WE;
    logic                ADV;
    logic [NIB_W-1:0]    PIXOUT;

    modport master (
        output BLK, PLUSONE, S, PIX, PIX_VALID, PIX_LAST, DRAM_DIN,
        input  PIX_READY, DRAM_DOUT, DRAM_RD, DRAM_WE, ADV, PIXOUT
    );

    modport slave (
        input  BLK, PLUSONE, S, PIX, PIX_VALID, PIX_LAST, DRAM_DIN,
        output PIX_READY, DRAM_DOUT, DRAM_RD, DRAM_WE, ADV, PIXOUT
    );

endinterface

// File: rtl/pixel_pair_rmw_pair_merge.sv
// Nibble merge: drawn slots replace DRAM nibbles, undrawn slots keep the read data.
// Latency: combinational.
// Backpressure: none.
module pixel_pair_rmw_pair_merge
    import pixel_pair_rmw_pkg::*;
(
    input  logic [PAIR_W-1:0] pair,
    input  logic [1:0]        mask,
    input  logic [PAIR_W-1:0] din,
    input  logic              s_q,
    output logic [PAIR_W-1:0] merged
);

    // With normal order slot0 lands in the high nibble; s_q swaps the two.
    logic hi_slot;
    logic lo_slot;

    assign hi_slot = s_q;
    assign lo_slot = ~s_q;

    // Per nibble: take the drawn colour where the mask is set, otherwise the DRAM byte.
    always_comb begin
        merged                = din;
        if (mask[hi_slot]) begin
            merged[PAIR_W-1:NIB_W] = slot_nib(pair, hi_slot);
        end
        if (mask[lo_slot]) begin
            merged[NIB_W-1:0] = slot_nib(pair, lo_slot);
        end
    end

endmodule

// File: rtl/pixel_pair_rmw.sv
// Packs drawn pixels into DRAM pixel pairs via read-modify-write; scans and erases pairs in display.
// Latency: flush RD->MRG->WR is 3 cycles (RD to WE exactly 2); scan emits one pixel per cycle.
// Backpressure: PIX_READY drops during every flush and whenever draw mode is not active.
module pixel_pair_rmw
    import pixel_pair_rmw_pkg::*;
#(
    parameter bit               CLEAR_ON_SCAN = 1'b1,
    parameter logic [NIB_W-1:0] TRANSP        = '0
)
(
    input  logic              CLK,
    input  logic              RST,
    pixel_pair_rmw_if.slave   bus
);

    state_t             state_q;
    state_t             state_d;

    logic               blk_m;
    logic               blk_s;
    logic [1:0]         settle_q;
    logic               sync_ok;

    logic               s_q;
    logic               ptr_q;
    logic               last_q;
    logic [PAIR_W-1:0]  pair_q;
    logic [1:0]         mask_q;
    logic [PAIR_W-1:0]  merged_q;
    logic [PAIR_W-1:0]  merged_c;
    logic               p_q;
    logic [NIB_W-1:0]   held_q;

    logic               cur_slot;
    logic               flush;
    logic               acc;
    logic               pix_rdy;
    logic               rd;
    logic               we;
    logic               adv;
    logic [PAIR_W-1:0]  dout;
    logic [NIB_W-1:0]   pixout;

    // The FSM ignores BLK until the synchroniser holds real samples, so reset never starts a scan.
    assign sync_ok  = settle_q[1];

    // The first pixel of a line takes its slot from PLUSONE; later ones follow the pointer.
    assign cur_slot = (state_q == ST_IDLE) ? (bus.PLUSONE ? SLOT1 : SLOT0) : ptr_q;
    assign flush    = (cur_slot == SLOT1) || bus.PIX_LAST;

    pixel_pair_rmw_pair_merge u_merge (
        .pair   (pair_q),
        .mask   (mask_q),
        .din    (bus.DRAM_DIN),
        .s_q    (s_q),
        .merged (merged_c)
    );

    // Two-flop synchroniser for the blanking input plus a settle marker.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blk_m    <= 1'b0;
            blk_s    <= 1'b0;
            settle_q <= 2'b00;
        end else begin
            blk_m    <= bus.BLK;
            blk_s    <= blk_m;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all strobes; outputs decode from registered state so reset zeroes them at once.
    always_comb begin
        state_d = state_q;
        pix_rdy = 1'b0;
        acc     = 1'b0;
        rd      = 1'b0;
        we      = 1'b0;
        adv     = 1'b0;
        dout    = '0;
        pixout  = '0;
        case (state_q)
            ST_IDLE: begin
                if (sync_ok) begin
                    if (blk_s) begin
                        pix_rdy = 1'b1;
                        if (bus.PIX_VALID) begin
                            acc     = 1'b1;
                            state_d = flush ? ST_RD : ST_FILL;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_FILL: begin
                if (!blk_s) begin
                    state_d = ST_SCAN;
                end else begin
                    pix_rdy = 1'b1;
                    if (bus.PIX_VALID) begin
                        acc     = 1'b1;
                        state_d = flush ? ST_RD : ST_FILL;
                    end
                end
            end
            ST_RD: begin
                rd      = 1'b1;
                state_d = ST_MRG;
            end
            ST_MRG: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                we   = 1'b1;
                adv  = 1'b1;
                dout = merged_q;
                if (!blk_s) begin
                    state_d = ST_SCAN;
                end else if (last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_SCAN: begin
                if (!p_q) begin
                    rd     = 1'b1;
                    pixout = held_q;
                end else begin
                    pixout = bus.DRAM_DIN[PAIR_W-1:NIB_W];
                    we     = CLEAR_ON_SCAN;
                    adv    = 1'b1;
                    if (blk_s) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pair collection, merge capture and scan phase/hold registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q      <= 1'b0;
            ptr_q    <= SLOT0;
            last_q   <= 1'b0;
            pair_q   <= '0;
            mask_q   <= 2'b00;
            merged_q <= '0;
            p_q      <= 1'b0;
            held_q   <= '0;
        end else begin
            if (acc) begin
                if (state_q == ST_IDLE) begin
                    s_q <= bus.S;
                end
                ptr_q <= ~cur_slot;
                if (bus.PIX != TRANSP) begin
                    if (cur_slot == SLOT1) begin
                        pair_q[PAIR_W-1:NIB_W] <= bus.PIX;
                    end else begin
                        pair_q[NIB_W-1:0] <= bus.PIX;
                    end
                    mask_q[cur_slot] <= 1'b1;
                end
                if (bus.PIX_LAST) begin
                    last_q <= 1'b1;
                end
            end
            if (state_q == ST_MRG) begin
                merged_q <= merged_c;
            end
            // A finished write or a drop into scan discards whatever was collected.
            if ((state_q == ST_WR) || (state_d == ST_SCAN)) begin
                pair_q <= '0;
                mask_q <= 2'b00;
                last_q <= 1'b0;
            end
            if (state_q == ST_SCAN) begin
                p_q <= ~p_q;
                if (p_q) begin
                    held_q <= bus.DRAM_DIN[NIB_W-1:0];
                end
            end else begin
                p_q    <= 1'b0;
                held_q <= '0;
            end
        end
    end

    assign bus.PIX_READY = pix_rdy;
    assign bus.DRAM_RD   = rd;
    assign bus.DRAM_WE   = we;
    assign bus.ADV       = adv;
    assign bus.DRAM_DOUT = dout;
    assign bus.PIXOUT    = pixout;

endmodule

// File: tb/tb_pixel_pair_rmw.sv
// Scoreboard bench for the pixel-pair read-modify-write stage.
// Latency: stimulus and checking run as separate processes on the falling edge.
// Backpressure: pixels are held until PIX_READY; DRAM reads are answered one cycle later.
module tb_pixel_pair_rmw;

    typedef struct {
        logic [7:0] dout;
        int         gap;
    } wr_t;

    logic CLK;
    logic RST;

    pixel_pair_rmw_if bus ();

    pixel_pair_rmw #(
        .CLEAR_ON_SCAN (1'b1),
        .TRANSP        (4'd0)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    wr_t        exp_wr[$];
    logic [3:0] exp_pix[$];
    logic [7:0] din_q[$];

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int last_rd = 0;

    // Free-running pixel clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errs++;
        $display("FAIL %s: timed out waiting for DUT, required event within bound", name);
    endtask

    task automatic expect_wr(input logic [7:0] d, input int gap);
        wr_t e;
        e.dout = d;
        e.gap  = gap;
        exp_wr.push_back(e);
    endtask

    task automatic send_pix(input logic [3:0] p, input logic last);
        int n = 0;
        bus.PIX       = p;
        bus.PIX_VALID = 1'b1;
        bus.PIX_LAST  = last;
        while (!bus.PIX_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) timeout_fail("pix_ready");
        @(negedge CLK);
        bus.PIX_VALID = 1'b0;
        bus.PIX_LAST  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_wr.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) timeout_fail("write_drain");
        repeat (2) @(negedge CLK);
    endtask

    // DRAM model: answers each read strobe with the next queued byte for the following cycle.
    initial begin
        bus.DRAM_DIN = 8'h00;
        forever begin
            @(negedge CLK);
            if (bus.DRAM_RD === 1'b1) begin
                if (din_q.size() != 0) bus.DRAM_DIN = din_q.pop_front();
                else                   bus.DRAM_DIN = 8'h00;
            end
        end
    end

    // Monitor: strobe rules every cycle, writes and scan pixels popped from the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            chk("strobe_excl", {31'd0, bus.DRAM_RD & bus.DRAM_WE}, 32'd0);
            chk("adv_only_with_we", {31'd0, bus.ADV}, {31'd0, bus.DRAM_WE});
            if (bus.DRAM_RD) last_rd = cyc;
            if (bus.DRAM_RD | bus.DRAM_WE)
                chk("ready_low_in_access", {31'd0, bus.PIX_READY}, 32'd0);
            if (bus.DRAM_WE) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_write: DRAM_WE=1 DOUT=0x%0h, required no write", bus.DRAM_DOUT);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_dout", {24'd0, bus.DRAM_DOUT}, {24'd0, e.dout});
                    chk("rd_to_we_gap", cyc - last_rd, e.gap);
                end
            end
            if ((bus.DRAM_RD | bus.DRAM_WE) && exp_pix.size() != 0)
                chk("pixout", {28'd0, bus.PIXOUT}, {28'd0, exp_pix.pop_front()});
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        RST           = 1'b1;
        bus.BLK       = 1'b1;
        bus.PLUSONE   = 1'b0;
        bus.S         = 1'b0;
        bus.PIX       = 4'h0;
        bus.PIX_VALID = 1'b0;
        bus.PIX_LAST  = 1'b0;

        @(negedge CLK);
        chk("rst_ready", {31'd0, bus.PIX_READY}, 32'd0);
        chk("rst_rd",    {31'd0, bus.DRAM_RD}, 32'd0);
        chk("rst_we",    {31'd0, bus.DRAM_WE}, 32'd0);
        chk("rst_adv",   {31'd0, bus.ADV}, 32'd0);
        chk("rst_dout",  {24'd0, bus.DRAM_DOUT}, 32'd0);
        chk("rst_pixout",{28'd0, bus.PIXOUT}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        chk("ready_idle_draw", {31'd0, bus.PIX_READY}, 32'd1);

        // Normal order pair: slot0 high nibble.
        din_q.push_back(8'hAA); expect_wr(8'h35, 2);
        send_pix(4'h3, 1'b0); send_pix(4'h5, 1'b1);
        drain();

        // Inverted nibble order.
        bus.S = 1'b1;
        din_q.push_back(8'hAA); expect_wr(8'h53, 2);
        send_pix(4'h3, 1'b0); send_pix(4'h5, 1'b1);
        drain();
        bus.S = 1'b0;

        // Odd-X start: single pixel goes to slot1 (low nibble).
        bus.PLUSONE = 1'b1;
        din_q.push_back(8'h47); expect_wr(8'h49, 2);
        send_pix(4'h9, 1'b1);
        drain();
        bus.PLUSONE = 1'b0;

        // Transparent slot0 keeps the DRAM nibble.
        din_q.push_back(8'hC1); expect_wr(8'hC6, 2);
        send_pix(4'h0, 1'b0); send_pix(4'h6, 1'b1);
        drain();

        // Fully transparent pair rewrites the byte unchanged.
        din_q.push_back(8'hC1); expect_wr(8'hC1, 2);
        send_pix(4'h0, 1'b0); send_pix(4'h0, 1'b1);
        drain();

        // Line ending on slot0: only slot0 replaced.
        din_q.push_back(8'h12); expect_wr(8'h72, 2);
        send_pix(4'h7, 1'b1);
        drain();

        // Two pairs in one line: flush on wrap, then continue in FILL.
        din_q.push_back(8'hFF); expect_wr(8'h12, 2);
        din_q.push_back(8'hFF); expect_wr(8'h34, 2);
        send_pix(4'h1, 1'b0); send_pix(4'h2, 1'b0);
        send_pix(4'h3, 1'b0); send_pix(4'h4, 1'b1);
        drain();

        // Scan: three pairs read, serialised and erased.
        din_q.push_back(8'h12); din_q.push_back(8'h34); din_q.push_back(8'h56);
        for (int i = 0; i < 6; i++) exp_pix.push_back(4'(i));
        for (int i = 0; i < 3; i++) expect_wr(8'h00, 1);
        bus.BLK = 1'b0;
        n = 0;
        while (!bus.DRAM_RD && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) timeout_fail("scan_start");
        repeat (2) @(negedge CLK);
        bus.BLK = 1'b1;
        drain();
        chk("pixout_after_scan", {28'd0, bus.PIXOUT}, 32'd0);
        chk("ready_after_scan",  {31'd0, bus.PIX_READY}, 32'd1);
        chk("scan_pix_drained",  exp_pix.size(), 32'd0);

        // BLK falls during RD: the write completes, then scan starts at p=0.
        din_q.push_back(8'h00); expect_wr(8'h89, 2);
        din_q.push_back(8'h77); din_q.push_back(8'h88);
        expect_wr(8'h00, 1); expect_wr(8'h00, 1);
        send_pix(4'h8, 1'b0); send_pix(4'h9, 1'b1);
        chk("in_rd_state", {31'd0, bus.DRAM_RD}, 32'd1);
        bus.BLK = 1'b0;
        n = 0;
        while (!bus.DRAM_WE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) timeout_fail("blk_fall_write");
        @(negedge CLK);
        chk("scan_p0_rd",     {31'd0, bus.DRAM_RD}, 32'd1);
        chk("scan_p0_pixout", {28'd0, bus.PIXOUT}, 32'd0);
        bus.BLK = 1'b1;
        drain();

        // Reset during MRG: no write may come out.
        din_q.push_back(8'h00);
        send_pix(4'h1, 1'b0); send_pix(4'h2, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_we",     {31'd0, bus.DRAM_WE}, 32'd0);
        chk("rst_mid_rd",     {31'd0, bus.DRAM_RD}, 32'd0);
        chk("rst_mid_adv",    {31'd0, bus.ADV}, 32'd0);
        chk("rst_mid_dout",   {24'd0, bus.DRAM_DOUT}, 32'd0);
        chk("rst_mid_ready",  {31'd0, bus.PIX_READY}, 32'd0);
        chk("rst_mid_pixout", {28'd0, bus.PIXOUT}, 32'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        chk("ready_after_rst", {31'd0, bus.PIX_READY}, 32'd1);

        // Recovery: a clean pair after the aborted one.
        din_q.push_back(8'h00); expect_wr(8'hAB, 2);
        send_pix(4'hA, 1'b0); send_pix(4'hB, 1'b1);
        drain();

        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        chk("din_queue_drained", din_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
